// File: rtl/cellrv32_npu_instr_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cellrv32_npu_instr_queue                                      |
// | Purpose  : In-order NPU instruction FIFO with compute/weight dispatch.   |
// |            Define CELLRV32_NPU_IQ_SYNC_EN to make SYNC wait for idle.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cellrv32_npu_instr_queue #(
  parameter int BUFFER_ADDRESS_WIDTH      = 24,
  parameter int ACCUMULATOR_ADDRESS_WIDTH = 16,
  parameter int LENGTH_WIDTH              = 32,
  parameter int OP_CODE_WIDTH             = 8,
  parameter int DEPTH                     = 4,
  localparam int WEIGHT_ADDRESS_WIDTH     = BUFFER_ADDRESS_WIDTH + ACCUMULATOR_ADDRESS_WIDTH,
  localparam int INSTR_W                  = OP_CODE_WIDTH + LENGTH_WIDTH + WEIGHT_ADDRESS_WIDTH,
  localparam int LVL_W                    = $clog2(DEPTH) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 in_valid_i,
  input  logic [INSTR_W-1:0]                   instr_i,
  output logic                                 in_ready_o,
  output logic                                 cmp_valid_o,
  input  logic                                 cmp_ready_i,
  output logic [OP_CODE_WIDTH-1:0]             cmp_opcode_o,
  output logic [LENGTH_WIDTH-1:0]              cmp_calc_len_o,
  output logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] cmp_acc_addr_o,
  output logic [BUFFER_ADDRESS_WIDTH-1:0]      cmp_buff_addr_o,
  output logic                                 wei_valid_o,
  input  logic                                 wei_ready_i,
  output logic [OP_CODE_WIDTH-1:0]             wei_opcode_o,
  output logic [LENGTH_WIDTH-1:0]              wei_calc_len_o,
  output logic [WEIGHT_ADDRESS_WIDTH-1:0]      wei_addr_o,
  input  logic [1:0]                           busy_i,
  output logic [LVL_W-1:0]                     level_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic                                 sync_wait_o
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [LVL_W-1:0]   r_level;

  logic [INSTR_W-1:0]                   w_head;
  logic [OP_CODE_WIDTH-1:0]             w_opcode;
  logic [LENGTH_WIDTH-1:0]              w_calc_len;
  logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] w_acc_addr;
  logic [BUFFER_ADDRESS_WIDTH-1:0]      w_buff_addr;
  logic w_is_nop, w_is_sync, w_is_wei, w_is_cmp;
  logic w_empty, w_full, w_in_ready, w_push, w_pop;
  logic w_sync_go, w_sync_wait;

  assign w_head      = r_mem[r_rptr];
  assign w_opcode    = w_head[INSTR_W-1 -: OP_CODE_WIDTH];
  assign w_calc_len  = w_head[WEIGHT_ADDRESS_WIDTH +: LENGTH_WIDTH];
  assign w_acc_addr  = w_head[BUFFER_ADDRESS_WIDTH +: ACCUMULATOR_ADDRESS_WIDTH];
  assign w_buff_addr = w_head[BUFFER_ADDRESS_WIDTH-1:0];

  assign w_is_nop  = (w_opcode == '0);
  assign w_is_sync = &w_opcode;
  assign w_is_wei  = w_opcode[OP_CODE_WIDTH-1] & ~w_is_sync;
  assign w_is_cmp  = ~w_opcode[OP_CODE_WIDTH-1] & ~w_is_nop;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == c_LVL_FULL);
  // A full queue refuses input even when the head pops in the same cycle.
  assign w_in_ready = ~w_full & ~rst_i & ~flush_i;
  assign w_push     = in_valid_i & w_in_ready;

`ifdef CELLRV32_NPU_IQ_SYNC_EN
  assign w_sync_go   = (busy_i == 2'b00);
  assign w_sync_wait = ~w_empty & w_is_sync & ~w_sync_go;
`else
  logic w_unused_busy;
  assign w_unused_busy = ^busy_i;
  assign w_sync_go     = 1'b1;
  assign w_sync_wait   = 1'b0;
`endif

  assign w_pop = ~w_empty & ((w_is_cmp & cmp_ready_i) | (w_is_wei & wei_ready_i) |
                             w_is_nop | (w_is_sync & w_sync_go));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= instr_i;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign in_ready_o      = w_in_ready;
  assign cmp_valid_o     = ~w_empty & w_is_cmp;
  assign wei_valid_o     = ~w_empty & w_is_wei;
  assign cmp_opcode_o    = w_opcode;
  assign cmp_calc_len_o  = w_calc_len;
  assign cmp_acc_addr_o  = w_acc_addr;
  assign cmp_buff_addr_o = w_buff_addr;
  assign wei_opcode_o    = w_opcode;
  assign wei_calc_len_o  = w_calc_len;
  assign wei_addr_o      = {w_acc_addr, w_buff_addr};
  assign level_o         = r_level;
  assign empty_o         = w_empty;
  assign full_o          = w_full;
  assign sync_wait_o     = w_sync_wait;

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_npu_instr_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cellrv32_npu_instr_queue                                   |
// | Purpose  : Scenario bench with a queue-based reference model.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_cellrv32_npu_instr_queue;
  localparam int BAW = 24, AAW = 16, LW = 32, OW = 8, DEPTH = 4;
  localparam int WAW = BAW + AAW, IW = OW + LW + WAW, LVW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, cmp_ready = 1'b0, wei_ready = 1'b0;
  logic [IW-1:0] instr = '0;
  logic [1:0]    busy = 2'b00;
  logic          in_ready, cmp_valid, wei_valid, empty, full, sync_wait;
  logic [OW-1:0]  cmp_opcode, wei_opcode;
  logic [LW-1:0]  cmp_len, wei_len;
  logic [AAW-1:0] cmp_acc;
  logic [BAW-1:0] cmp_buff;
  logic [WAW-1:0] wei_addr;
  logic [LVW-1:0] level;

  cellrv32_npu_instr_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .instr_i(instr),
    .in_ready_o(in_ready), .cmp_valid_o(cmp_valid), .cmp_ready_i(cmp_ready),
    .cmp_opcode_o(cmp_opcode), .cmp_calc_len_o(cmp_len), .cmp_acc_addr_o(cmp_acc),
    .cmp_buff_addr_o(cmp_buff), .wei_valid_o(wei_valid), .wei_ready_i(wei_ready),
    .wei_opcode_o(wei_opcode), .wei_calc_len_o(wei_len), .wei_addr_o(wei_addr),
    .busy_i(busy), .level_o(level), .empty_o(empty), .full_o(full), .sync_wait_o(sync_wait)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] q[$];
  int total = 0, bad = 0;

  function automatic logic [IW-1:0] mk(logic [7:0] op, logic [31:0] len, logic [15:0] acc,
                                       logic [23:0] buff);
    return {op, len, acc, buff};
  endfunction

  // 0 = NOP, 1 = SYNC, 2 = weight, 3 = compute
  function automatic int cls(logic [IW-1:0] w);
    logic [OW-1:0] op;
    op = w[IW-1 -: OW];
    if (op == '0) return 0;
    if (op == '1) return 1;
    if (op[OW-1]) return 2;
    return 3;
  endfunction

  function automatic bit sync_ok(logic [1:0] b);
`ifdef CELLRV32_NPU_IQ_SYNC_EN
    return b == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int head_cls();
    if (q.size() == 0) return -1;
    return cls(q[0]);
  endfunction

  function automatic bit exp_sync_wait();
`ifdef CELLRV32_NPU_IQ_SYNC_EN
    return head_cls() == 1 && busy != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model with the inputs currently driven, then cross one rising edge.
  task automatic tick();
    bit push, pop;
    int c;
    push = in_valid && !rst && !flush && q.size() < DEPTH;
    if (rst || flush) q.delete();
    else begin
      c   = head_cls();
      pop = (c == 0) || (c == 1 && sync_ok(busy)) || (c == 2 && wei_ready) || (c == 3 && cmp_ready);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(instr);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [IW-1:0] rand_instr();
    logic [7:0] op;
    case ($urandom_range(0, 3))
      0: op = 8'h00;
      1: op = 8'hFF;
      2: begin op = {1'b1, 7'($urandom)}; if (op == 8'hFF) op = 8'h80; end
      default: begin op = {1'b0, 7'($urandom)}; if (op == 8'h00) op = 8'h01; end
    endcase
    return mk(op, $urandom, 16'($urandom), 24'($urandom));
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instr = mk(8'h05, 32'd3, 16'h1, 24'h2);
    tick(); tick(); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if ({level, empty, full} !== {LVW'(0), 1'b1, 1'b0}) begin bad++;
      $display("FAIL reset_status got lvl=%0d empty=%b full=%b exp 0/1/0", level, empty, full); end
    total++; if ({cmp_valid, wei_valid, sync_wait} !== 3'b000) begin bad++;
      $display("FAIL reset_valids got=%b%b%b exp=000", cmp_valid, wei_valid, sync_wait); end
    total++; if ({cmp_opcode, cmp_len, cmp_acc, cmp_buff, wei_opcode, wei_len, wei_addr} !== '0) begin bad++;
      $display("FAIL reset_fields got cmp_op=%h wei_addr=%h exp=0", cmp_opcode, wei_addr); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_compute();
    instr = mk(8'h01, 32'd16, 16'h0010, 24'h000100); in_valid = 1'b1; cmp_ready = 1'b0; #1;
    total++; if (in_ready !== 1'b1 || cmp_valid !== 1'b0) begin bad++;
      $display("FAIL cmp_pre got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, cmp_valid); end
    tick(); in_valid = 1'b0; #1;
    total++; if (cmp_valid !== 1'b1 || wei_valid !== 1'b0 || level !== LVW'(1)) begin bad++;
      $display("FAIL cmp_issue got cv=%b wv=%b lvl=%0d exp 1/0/1", cmp_valid, wei_valid, level); end
    total++; if ({cmp_opcode, cmp_len, cmp_acc, cmp_buff} !== {8'h01, 32'd16, 16'h0010, 24'h000100}) begin
      bad++; $display("FAIL cmp_fields got %h %h %h %h", cmp_opcode, cmp_len, cmp_acc, cmp_buff); end
    cmp_ready = 1'b1; tick(); #1;
    total++; if (level !== LVW'(0) || cmp_valid !== 1'b0) begin bad++;
      $display("FAIL cmp_pop got lvl=%0d vld=%b exp 0/0", level, cmp_valid); end
    cmp_ready = 1'b0;
  endtask

  task automatic test_weight_hold();
    instr = mk(8'h81, 32'd8, 16'hABCD, 24'h123456); in_valid = 1'b1; wei_ready = 1'b0;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (wei_valid !== 1'b1 || cmp_valid !== 1'b0 || wei_addr !== 40'hABCD123456 ||
                   wei_opcode !== 8'h81 || wei_len !== 32'd8) begin bad++;
        $display("FAIL wei_hold cyc=%0d got wv=%b cv=%b addr=%h op=%h len=%0d exp 1/0/abcd123456/81/8",
                 i, wei_valid, cmp_valid, wei_addr, wei_opcode, wei_len); end
      tick();
    end
    wei_ready = 1'b1; tick(); #1;
    total++; if (level !== LVW'(0) || wei_valid !== 1'b0) begin bad++;
      $display("FAIL wei_pop got lvl=%0d wv=%b exp 0/0", level, wei_valid); end
    wei_ready = 1'b0;
  endtask

  task automatic test_fill_wrap();
    cmp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instr = mk(8'h10 + 8'(i), 32'(i), 16'(i), 24'(i)); in_valid = 1'b1; #1;
      if (i == 4) begin
        total++; if (in_ready !== 1'b0 || full !== 1'b1 || level !== LVW'(4)) begin bad++;
          $display("FAIL full got rdy=%b full=%b lvl=%0d exp 0/1/4", in_ready, full, level); end
      end
      tick();
    end
    in_valid = 1'b0; cmp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (cmp_valid !== 1'b1 || cmp_opcode !== 8'h10 + 8'(i)) begin bad++;
        $display("FAIL drain_order idx=%0d got vld=%b op=%h exp op=%h", i, cmp_valid, cmp_opcode, 8'h10 + 8'(i)); end
      tick();
    end
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
    for (int i = 0; i < 10; i++) begin
      instr = mk(8'h20 + 8'(i), $urandom, 16'($urandom), 24'($urandom));
      in_valid = 1'b1; cmp_ready = 1'($urandom_range(0, 1)); #1;
      total++; if (level !== LVW'(q.size()) || (q.size() > 0 && {cmp_opcode, cmp_len} !== q[0][IW-1 -: OW+LW])) begin
        bad++; $display("FAIL wrap idx=%0d got lvl=%0d op=%h exp lvl=%0d", i, level, cmp_opcode, q.size()); end
      tick();
    end
    in_valid = 1'b0; cmp_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    cmp_ready = 1'b0;
  endtask

  task automatic test_nop_bubble();
    logic [IW-1:0] seq [3];
    logic [2:0]    exp [4];
    seq[0] = mk(8'h02, 32'd1, 16'h1, 24'h1); seq[1] = '0; seq[2] = mk(8'h90, 32'd2, 16'h2, 24'h2);
    exp[0] = 3'b101; exp[1] = 3'b001; exp[2] = 3'b011; exp[3] = 3'b000;  // {cmp,wei,level!=0}
    cmp_ready = 1'b1; wei_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3); instr = (i < 3) ? seq[i] : '0;
      tick(); #1;
      total++; if ({cmp_valid, wei_valid, level != 0} !== exp[i]) begin bad++;
        $display("FAIL nop_bubble cyc=%0d got cv=%b wv=%b lvl=%0d exp=%b", i, cmp_valid, wei_valid, level, exp[i]); end
    end
    in_valid = 1'b0; cmp_ready = 1'b0; wei_ready = 1'b0;
  endtask

  task automatic test_sync();
    busy = 2'b10; in_valid = 1'b1; instr = mk(8'hFF, 32'd0, 16'h0, 24'h0);
    tick(); instr = mk(8'h03, 32'd7, 16'h7, 24'h7);
`ifdef CELLRV32_NPU_IQ_SYNC_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (sync_wait !== 1'b1 || cmp_valid !== 1'b0) begin bad++;
        $display("FAIL sync_wait cyc=%0d got sw=%b cv=%b exp 1/0", i, sync_wait, cmp_valid); end
      tick(); in_valid = 1'b0;
    end
    busy = 2'b00; #1;
    total++; if (sync_wait !== 1'b0 || cmp_valid !== 1'b0) begin bad++;
      $display("FAIL sync_release got sw=%b cv=%b exp 0/0", sync_wait, cmp_valid); end
    tick();
`else
    #1;
    total++; if (sync_wait !== 1'b0 || cmp_valid !== 1'b0 || level !== LVW'(1)) begin bad++;
      $display("FAIL sync_nop got sw=%b cv=%b lvl=%0d exp 0/0/1", sync_wait, cmp_valid, level); end
    tick(); in_valid = 1'b0;
`endif
    #1;
    total++; if (cmp_valid !== 1'b1 || cmp_opcode !== 8'h03) begin bad++;
      $display("FAIL sync_after got cv=%b op=%h exp 1/03", cmp_valid, cmp_opcode); end
    cmp_ready = 1'b1; tick(); cmp_ready = 1'b0; busy = 2'b00;
  endtask

  task automatic test_flush();
    cmp_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin instr = mk(8'h40 + 8'(i), 32'(i), 16'h0, 24'h0); tick(); end
    flush = 1'b1; instr = mk(8'h4F, 32'd9, 16'h9, 24'h9); #1;
    total++; if (in_ready !== 1'b0 || level !== LVW'(3)) begin bad++;
      $display("FAIL flush_pre got rdy=%b lvl=%0d exp 0/3", in_ready, level); end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    total++; if (level !== LVW'(0) || empty !== 1'b1 || cmp_valid !== 1'b0) begin bad++;
      $display("FAIL flush_post got lvl=%0d empty=%b cv=%b exp 0/1/0", level, empty, cmp_valid); end
    tick(); #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_drop got empty=%b exp=1", empty); end
  endtask

  task automatic test_random();
    int c;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0); flush = ($urandom_range(0, 39) == 0);
      in_valid = 1'($urandom); instr = rand_instr();
      cmp_ready = 1'($urandom); wei_ready = 1'($urandom); busy = 2'($urandom); #1;
      c = head_cls();
      total++;
      if (level !== LVW'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          in_ready !== (!rst && !flush && q.size() < DEPTH) || cmp_valid !== (c == 3) ||
          wei_valid !== (c == 2) || sync_wait !== exp_sync_wait()) begin
        bad++; $display("FAIL rand_ctrl n=%0d got lvl=%0d rdy=%b cv=%b wv=%b sw=%b exp lvl=%0d cls=%0d",
                        n, level, in_ready, cmp_valid, wei_valid, sync_wait, q.size(), c);
      end else if (c >= 0 && ({cmp_opcode, cmp_len, cmp_acc, cmp_buff} !== q[0] ||
                              {wei_opcode, wei_len, wei_addr} !== q[0])) begin
        bad++; $display("FAIL rand_fields n=%0d got %h exp %h", n, {cmp_opcode, cmp_len, cmp_acc, cmp_buff}, q[0]);
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; busy = 2'b00;
  endtask

  initial begin
    test_reset();
    test_compute();
    test_weight_hold();
    test_fill_wrap();
    test_nop_bubble();
    test_sync();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cellrv32_npu_instr_queue.md
# cellrv32_npu_instr_queue

Parametrised instruction queue and dispatcher for the CELLRV32 NPU. It buffers packed NPU instruction words from the CPU-side command interface in a DEPTH-entry in-order FIFO. Each head entry is issued to one of two downstream channels: the compute channel (matrix/activation path, unpacked as opcode/calc_len/acc_addr/buff_addr) or the weight channel (weight loader, unpacked as opcode/calc_len/wei_addr). An optional SYNC barrier holds issue until both units are idle.

## Interface
- BUFFER_ADDRESS_WIDTH, 24, unified-buffer address width
- ACCUMULATOR_ADDRESS_WIDTH, 16, accumulator address width
- LENGTH_WIDTH, 32, calc_len width
- OP_CODE_WIDTH, 8, opcode width (≥2)
- DEPTH, 4, queue entries; power of two, ≥2
- Derived: WEIGHT_ADDRESS_WIDTH = BUFFER_ADDRESS_WIDTH + ACCUMULATOR_ADDRESS_WIDTH; INSTR_W = OP_CODE_WIDTH + LENGTH_WIDTH + WEIGHT_ADDRESS_WIDTH; LVL_W = $clog2(DEPTH)+1
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous queue clear
- in_valid_i  in  1  instr_i valid
- instr_i  in  INSTR_W  packed {opcode, calc_len, acc_addr, buff_addr}, opcode in MSBs
- in_ready_o  out  1  queue accepts instr_i
- cmp_valid_o / cmp_ready_i  out/in  1  compute channel handshake
- cmp_opcode_o, cmp_calc_len_o, cmp_acc_addr_o, cmp_buff_addr_o  out  field widths  head fields
- wei_valid_o / wei_ready_i  out/in  1  weight channel handshake
- wei_opcode_o, wei_calc_len_o  out  field widths  head fields
- wei_addr_o  out  WEIGHT_ADDRESS_WIDTH  {acc_addr, buff_addr} of head
- busy_i  in  2  bit0 compute unit busy, bit1 weight unit busy
- level_o  out  LVL_W  entries held (0..DEPTH)
- empty_o, full_o  out  1  level_o==0 / level_o==DEPTH
- sync_wait_o  out  1  SYNC at head, waiting for idle

## Operation
- Opcode classes by head opcode: all-zero = NOP; all-ones = SYNC; MSB set (not all-ones) = weight; else compute.
- Enqueue when in_valid_i & in_ready_o; in_ready_o = !full_o & !rst_i & !flush_i. Full queue: no pop-through; in_ready_o stays 0 that cycle even if head pops.
- Head dispatch (only when !empty_o): compute → cmp_valid_o=1, pop on cmp_ready_i; weight → wei_valid_o=1, pop on wei_ready_i; NOP → popped internally, no valid asserted; SYNC → see Configuration. At most one valid is high per cycle.
- Data fields on both channels always reflect the head entry; valid qualifies them. Once asserted, a valid stays high with stable fields until accepted (AXI-style); ready may be high before valid.
- Issue strictly in order; a stalled head blocks both channels.
- Pointers: read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; level counter increments on push only, decrements on pop only, unchanged on simultaneous push+pop.
- flush_i: pointers and level to 0 next edge; takes priority over push/pop in the same cycle; in-flight valid drops next cycle.

## Timing
- Reset (rst_i high at edge): level_o=0, empty_o=1, full_o=0, cmp_valid_o=0, wei_valid_o=0, sync_wait_o=0, all field outputs 0; in_ready_o=0 while rst_i high. Reset mid-transfer discards queued entries.
- Latency: instruction accepted at edge N appears at head (valid high) from cycle N+1 if queue was empty; no combinational in→out path.
- Throughput: one instruction per cycle per direction; NOP consumes one cycle at head.
- Outputs derived from registered state (head entry, level); valid may combinationally depend on busy_i only for SYNC.

## Configuration
- CELLRV32_NPU_IQ_SYNC_EN defined: SYNC at head asserts sync_wait_o while busy_i != 2'b00; pops in the first cycle busy_i == 2'b00 (sync_wait_o low that cycle); no valid asserted for SYNC.
- Not defined: SYNC treated as NOP (popped next cycle, no wait); sync_wait_o tied 0; busy_i unused.

## Test plan
- Reset then push compute {opcode 8'h01, calc_len 32'd16, acc 16'h0010, buff 24'h000100} → cmp_valid_o cycle after accept with those fields; wei_valid_o=0; level 1→0 on cmp_ready_i.
- Push weight {8'h81, len 8, acc 16'hABCD, buff 24'h123456} → wei_valid_o=1, wei_addr_o=40'hABCD123456; hold wei_ready_i=0 for 5 cycles → fields stable, valid held.
- Fill DEPTH=4 with ready low → full_o=1, in_ready_o=0; fifth in_valid_i ignored; drain yields original order; wrap verified over 10 pushes.
- Sequence compute, NOP, weight with both readies high → compute issued, one-cycle bubble, weight issued; level ends 0.
- SYNC_EN: push SYNC then compute with busy_i=2'b10 for 3 cycles → sync_wait_o=1 for 3 cycles, compute valid only after busy_i=0; without macro SYNC passes in 1 cycle.
- flush_i with 3 entries and simultaneous push → level_o=0, empty_o=1 next cycle, pushed entry dropped.
